// File: rtl/dc_pkg.sv
// Shared definitions for the DC DAC SPI writer: FSM states, word width and the
// default frame length.
package dc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    LDAC  = 2'd3
  } state_t;

  localparam int WORD_W          = 32;
  localparam int FRAME_WORDS_DEF = 62;

endpackage

// File: rtl/dc_dac_spi_writer_if.sv
// Frame input and SPI/status outputs of the DC DAC writer, bundled so the
// producer side and the writer side each see one port.
interface dc_dac_spi_writer_if
  import dc_pkg::*;
#(
  parameter int DAC_CHANNEL = 24,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF
);

  logic [FRAME_WORDS-1:0][WORD_W-1:0] i_dc_regs;
  logic [4:0]                         i_channel_sel;
  logic                               i_valid_frame;
  logic                               o_sclk;
  logic                               o_mosi;
  logic [DAC_CHANNEL-1:0]             o_cs_n;
  logic                               o_ldac_n;
  logic                               o_busy;
  logic                               o_done;
  logic                               o_err;
  logic [7:0]                         o_drop_cnt;

  modport master (
    output i_dc_regs, i_channel_sel, i_valid_frame,
    input  o_sclk, o_mosi, o_cs_n, o_ldac_n, o_busy, o_done, o_err, o_drop_cnt
  );

  modport slave (
    input  i_dc_regs, i_channel_sel, i_valid_frame,
    output o_sclk, o_mosi, o_cs_n, o_ldac_n, o_busy, o_done, o_err, o_drop_cnt
  );

endinterface

// File: rtl/dc_dac_spi_writer_shifter.sv
// Serialises one 32-bit word as SPI mode 0, MSB first, with a programmable
// half-period divider; word_done marks the final cycle of the last high half.
module spi_word_shifter
  import dc_pkg::*;
#(
  parameter int SCLK_DIV = 4
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  output logic              sclk,
  output logic              mosi,
  output logic              word_done
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W = $clog2(WORD_W);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  logic              active;
  logic              sclk_q;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] sreg;
  logic              half_end;

  assign half_end  = active && (div_cnt == DIV_MAX);
  assign word_done = half_end && sclk_q && (bit_cnt == LAST_BIT);
  assign sclk      = sclk_q;
  assign mosi      = sreg[WORD_W-1];

  // Data only moves when a high half ends, so MOSI changes exactly as SCLK falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      sclk_q  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sreg    <= '0;
    end else if (load) begin
      active  <= 1'b1;
      sclk_q  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sreg    <= word;
    end else if (active) begin
      if (half_end) begin
        div_cnt <= '0;
        if (!sclk_q) begin
          sclk_q <= 1'b1;
        end else begin
          sclk_q <= 1'b0;
          if (bit_cnt == LAST_BIT) begin
            active <= 1'b0;
            sreg   <= '0;
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
            sreg    <= {sreg[WORD_W-2:0], 1'b0};
          end
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/dc_dac_spi_writer.sv
// Frame-level DAC writer: buffers a frame, shifts payload words to one DAC with
// CS gaps between words, then strobes LDAC and reports done/error/drops.
module dc_dac_spi_writer
  import dc_pkg::*;
#(
  parameter int DAC_CHANNEL = 24,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int SCLK_DIV    = 4,
  parameter int CS_GAP      = 4
)
(
  input  logic                i_clk,
  input  logic                i_rst,
  dc_dac_spi_writer_if.slave  bus
);

  localparam int IDX_W = $clog2(FRAME_WORDS);
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(CS_GAP - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  word_idx;
  logic [4:0]        ch_q;
  logic [GAP_W-1:0]  gap_cnt;
  logic              ldac_cnt;
  logic              done_q, err_q;
  logic [7:0]        drop_cnt;
  logic [WORD_W-1:0] frame_buf [FRAME_WORDS-1];

  logic              load, accept, reject, drop, done_d, chan_ok, gap_end;
  logic [WORD_W-1:0] load_word;
  logic              word_done, sclk, mosi;
  logic              hdr_unused;

  assign hdr_unused = ^bus.i_dc_regs[0];
  assign chan_ok    = 32'(bus.i_channel_sel) < 32'(DAC_CHANNEL);
  assign gap_end    = (state_q == GAP) && (gap_cnt == GAP_MAX);

  // Next-state and control strobes; frame_buf[k] holds payload word k+1.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    done_d    = 1'b0;
    load_word = frame_buf[word_idx];
    drop      = bus.i_valid_frame && ((state_q != IDLE) || done_q);
    case (state_q)
      IDLE: begin
        if (bus.i_valid_frame && !done_q) begin
          if (chan_ok) begin
            accept    = 1'b1;
            load      = 1'b1;
            load_word = bus.i_dc_regs[1];
            state_d   = SHIFT;
          end else begin
            reject = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (word_done) state_d = GAP;
      end
      GAP: begin
        if (gap_end) begin
          if (word_idx == LAST_IDX) begin
            state_d = LDAC;
          end else begin
            load    = 1'b1;
            state_d = SHIFT;
          end
        end
      end
      LDAC: begin
        if (ldac_cnt) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Frame counters and status pulses, all cleared by reset so an abort is clean.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      word_idx <= '0;
      ch_q     <= '0;
      gap_cnt  <= '0;
      ldac_cnt <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      drop_cnt <= '0;
    end else begin
      done_q   <= done_d;
      err_q    <= reject;
      ldac_cnt <= (state_q == LDAC) ? ~ldac_cnt : 1'b0;
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      if ((state_q == GAP) && !gap_end) gap_cnt <= gap_cnt + GAP_W'(1);
      else                              gap_cnt <= '0;
      if (accept) begin
        ch_q     <= bus.i_channel_sel;
        word_idx <= IDX_W'(1);
      end else if (gap_end && (word_idx != LAST_IDX)) begin
        word_idx <= word_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int k = 0; k < FRAME_WORDS - 1; k++) frame_buf[k] <= bus.i_dc_regs[k+1];
    end
  end

  spi_word_shifter #(.SCLK_DIV(SCLK_DIV)) u_shifter (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (load),
    .word      (load_word),
    .sclk      (sclk),
    .mosi      (mosi),
    .word_done (word_done)
  );

  assign bus.o_sclk     = sclk;
  assign bus.o_mosi     = mosi;
  assign bus.o_cs_n     = (state_q == SHIFT) ? ~(DAC_CHANNEL'(1) << ch_q) : '1;
  assign bus.o_ldac_n   = (state_q != LDAC);
  assign bus.o_busy     = (state_q != IDLE);
  assign bus.o_done     = done_q;
  assign bus.o_err      = err_q;
  assign bus.o_drop_cnt = drop_cnt;

endmodule
